// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset controller: FSM states,
// opcode/funct values, ALU operations and datapath mux selects.
package mips_ctrl_pkg;

  localparam int OP_W     = 6;
  localparam int ALU_OP_W = 4;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    EXEC_R    = 4'd2,
    EXEC_I    = 4'd3,
    MEM_ADDR  = 4'd4,
    MEM_READ  = 4'd5,
    MEM_WRITE = 4'd6,
    WB_ALU    = 4'd7,
    WB_MEM    = 4'd8,
    BRANCH    = 4'd9,
    JUMP      = 4'd10,
    HALT      = 4'd11
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_JR  = 6'h08;

  // ALU operations
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_XOR = 4'd2;
  localparam logic [3:0] ALU_SLT = 4'd3;

  // PC source select
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_RS     = 2'b11;

  // Register-file destination select
  localparam logic [1:0] REG_DST_RT = 2'b00;
  localparam logic [1:0] REG_DST_RD = 2'b01;
  localparam logic [1:0] REG_DST_RA = 2'b10;

  // Register-file write-data select
  localparam logic [1:0] MEM_TO_REG_ALUOUT = 2'b00;
  localparam logic [1:0] MEM_TO_REG_MDR    = 2'b01;
  localparam logic [1:0] MEM_TO_REG_PC     = 2'b10;

  // ALU B operand select
  localparam logic [1:0] ALU_B_REG     = 2'b00;
  localparam logic [1:0] ALU_B_FOUR    = 2'b01;
  localparam logic [1:0] ALU_B_IMM     = 2'b10;
  localparam logic [1:0] ALU_B_IMM_SH2 = 2'b11;

  // Complete set of datapath controls driven by the FSM in one cycle.
  typedef struct packed {
    logic       pc_we;
    logic [1:0] pc_src;
    logic       ir_we;
    logic       iord;
    logic       mem_re;
    logic       mem_we;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
  } ctrl_t;

  // All enables low, all selects at their zero encoding.
  function automatic ctrl_t ctrl_idle();
    return '0;
  endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Maps an R-type funct field to the ALU operation; valid is low for any
// funct that is not an ALU instruction handled by this controller.
module alu_op_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int OP_W     = 6,
  parameter int ALU_OP_W = 4
) (
  input  logic [OP_W-1:0]     funct,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                valid
);

  // Pure lookup of the supported R-type ALU functions.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    alu_op = ALU_ADD;
    valid  = 1'b0;
    case (funct)
      FN_ADD: begin alu_op = ALU_ADD; valid = 1'b1; end
      FN_SUB: begin alu_op = ALU_SUB; valid = 1'b1; end
      FN_SLT: begin alu_op = ALU_SLT; valid = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the shared multicycle MIPS-subset datapath. Sequences
// fetch/decode/execute/memory/writeback and drives every enable and select.
// Only the fetch/memory handshakes (mem_ready) and the BNE decision (zero)
// reach the outputs combinationally; everything else follows the state.
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int OP_W     = 6,
  parameter int ALU_OP_W = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [OP_W-1:0]     opcode,
  input  logic [OP_W-1:0]     funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_we,
  output logic [1:0]          pc_src,
  output logic                ir_we,
  output logic                iord,
  output logic                mem_re,
  output logic                mem_we,
  output logic                reg_we,
  output logic [1:0]          reg_dst,
  output logic [1:0]          mem_to_reg,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                illegal
);

  state_t              state;
  state_t              state_next;
  logic                illegal_q;
  logic                illegal_set;
  ctrl_t               ctrl;
  logic [ALU_OP_W-1:0] r_alu_op;
  logic                r_alu_valid;
  logic                is_rtype;
  logic                is_jr;

  alu_op_decoder #(
    .OP_W     (OP_W),
    .ALU_OP_W (ALU_OP_W)
  ) u_alu_op_decoder (
    .funct  (funct),
    .alu_op (r_alu_op),
    .valid  (r_alu_valid)
  );

  assign is_rtype = (opcode == OP_RTYPE);
  assign is_jr    = is_rtype && (funct == FN_JR);

  // State register and sticky illegal flag, synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset_n) begin
      state     <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state <= state_next;
      if (illegal_set) illegal_q <= 1'b1;
    end
  end

  // Next-state and per-state datapath controls.
  always_comb begin
    ctrl        = ctrl_idle();
    state_next  = state;
    illegal_set = 1'b0;

    case (state)
      FETCH: begin
        ctrl.mem_re    = 1'b1;
        ctrl.iord      = 1'b0;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = ALU_B_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_src    = PC_SRC_ALU;
        // IR load and PC+4 commit only when the instruction word arrives.
        if (mem_ready) begin
          ctrl.ir_we = 1'b1;
          ctrl.pc_we = 1'b1;
          state_next = DECODE;
        end
      end

      DECODE: begin
        // Speculatively form PC+4 + (imm<<2) so BRANCH finds it in ALUOut.
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = ALU_B_IMM_SH2;
        ctrl.alu_op    = ALU_ADD;
        case (opcode)
          OP_RTYPE: begin
            if (r_alu_valid) begin
              state_next = EXEC_R;
            end else if (is_jr) begin
              state_next = JUMP;
            end else begin
              state_next  = HALT;
              illegal_set = 1'b1;
            end
          end
          OP_ADDI, OP_XORI: state_next = EXEC_I;
          OP_LW, OP_SW:     state_next = MEM_ADDR;
          OP_BNE:           state_next = BRANCH;
          OP_J, OP_JAL:     state_next = JUMP;
          default: begin
            state_next  = HALT;
            illegal_set = 1'b1;
          end
        endcase
      end

      EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALU_B_REG;
        ctrl.alu_op    = r_alu_op;
        state_next     = WB_ALU;
      end

      EXEC_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALU_B_IMM;
        ctrl.alu_op    = (opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
        state_next     = WB_ALU;
      end

      WB_ALU: begin
        ctrl.reg_we     = 1'b1;
        ctrl.mem_to_reg = MEM_TO_REG_ALUOUT;
        ctrl.reg_dst    = is_rtype ? REG_DST_RD : REG_DST_RT;
        state_next      = FETCH;
      end

      MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALU_B_IMM;
        ctrl.alu_op    = ALU_ADD;
        state_next     = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
      end

      MEM_READ: begin
        // Request held steady until the memory completes it.
        ctrl.mem_re = 1'b1;
        ctrl.iord   = 1'b1;
        if (mem_ready) state_next = WB_MEM;
      end

      WB_MEM: begin
        ctrl.reg_we     = 1'b1;
        ctrl.reg_dst    = REG_DST_RT;
        ctrl.mem_to_reg = MEM_TO_REG_MDR;
        state_next      = FETCH;
      end

      MEM_WRITE: begin
        ctrl.mem_we = 1'b1;
        ctrl.iord   = 1'b1;
        if (mem_ready) state_next = FETCH;
      end

      BRANCH: begin
        // BNE: compare rs-rt; take the precomputed target when nonzero.
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALU_B_REG;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_src    = PC_SRC_ALUOUT;
        ctrl.pc_we     = ~zero;
        state_next     = FETCH;
      end

      JUMP: begin
        ctrl.pc_we = 1'b1;
        if (is_rtype) begin
          ctrl.pc_src = PC_SRC_RS;
        end else begin
          ctrl.pc_src = PC_SRC_JUMP;
          // PC already holds the return address (PC+4) from FETCH.
          if (opcode == OP_JAL) begin
            ctrl.reg_we     = 1'b1;
            ctrl.reg_dst    = REG_DST_RA;
            ctrl.mem_to_reg = MEM_TO_REG_PC;
          end
        end
        state_next = FETCH;
      end

      HALT: state_next = HALT;

      default: state_next = FETCH;
    endcase
  end

  // Output drive; reset forces every control low without waiting for an edge.
  always_comb begin
    if (reset_n) begin
      pc_we      = ctrl.pc_we;
      pc_src     = ctrl.pc_src;
      ir_we      = ctrl.ir_we;
      iord       = ctrl.iord;
      mem_re     = ctrl.mem_re;
      mem_we     = ctrl.mem_we;
      reg_we     = ctrl.reg_we;
      reg_dst    = ctrl.reg_dst;
      mem_to_reg = ctrl.mem_to_reg;
      alu_src_a  = ctrl.alu_src_a;
      alu_src_b  = ctrl.alu_src_b;
      alu_op     = ctrl.alu_op;
      illegal    = illegal_q;
    end else begin
      pc_we      = 1'b0;
      pc_src     = '0;
      ir_we      = 1'b0;
      iord       = 1'b0;
      mem_re     = 1'b0;
      mem_we     = 1'b0;
      reg_we     = 1'b0;
      reg_dst    = '0;
      mem_to_reg = '0;
      alu_src_a  = 1'b0;
      alu_src_b  = '0;
      alu_op     = '0;
      illegal    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: a table of per-cycle
// {inputs, expected controls} records plus hand-written corner sequences.
module tb_multicycle_controller;

  typedef struct packed {
    logic       pc_we;
    logic [1:0] pc_src;
    logic       ir_we;
    logic       iord;
    logic       mem_re;
    logic       mem_we;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       illegal;
  } outs_t;

  typedef struct packed {
    logic [8*12-1:0] name;
    logic            rn;
    logic [5:0]      op;
    logic [5:0]      fn;
    logic            z;
    logic            rdy;
    outs_t           exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_we, ir_we, iord, mem_re, mem_we, reg_we, alu_src_a, illegal;
  logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b;
  logic [3:0] alu_op;

  int checks = 0;
  int errors = 0;
  vec_t vec_q[$];

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .ir_we      (ir_we),
    .iord       (iord),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .reg_we     (reg_we),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .illegal    (illegal)
  );

  // Expected control words per state, written straight from the state table.
  function automatic outs_t o_zero();
    return '0;
  endfunction
  function automatic outs_t o_fetch(input logic rdy);
    outs_t o = '0;
    o.mem_re = 1'b1; o.alu_src_b = 2'b01; o.ir_we = rdy; o.pc_we = rdy;
    return o;
  endfunction
  function automatic outs_t o_decode();
    outs_t o = '0;
    o.alu_src_b = 2'b11;
    return o;
  endfunction
  function automatic outs_t o_exec_r(input logic [3:0] aop);
    outs_t o = '0;
    o.alu_src_a = 1'b1; o.alu_op = aop;
    return o;
  endfunction
  function automatic outs_t o_exec_i(input logic [3:0] aop);
    outs_t o = '0;
    o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_op = aop;
    return o;
  endfunction
  function automatic outs_t o_mem_addr();
    outs_t o = '0;
    o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
    return o;
  endfunction
  function automatic outs_t o_mem_read();
    outs_t o = '0;
    o.mem_re = 1'b1; o.iord = 1'b1;
    return o;
  endfunction
  function automatic outs_t o_mem_write();
    outs_t o = '0;
    o.mem_we = 1'b1; o.iord = 1'b1;
    return o;
  endfunction
  function automatic outs_t o_wb_alu(input logic [1:0] dst);
    outs_t o = '0;
    o.reg_we = 1'b1; o.reg_dst = dst;
    return o;
  endfunction
  function automatic outs_t o_wb_mem();
    outs_t o = '0;
    o.reg_we = 1'b1; o.mem_to_reg = 2'b01;
    return o;
  endfunction
  function automatic outs_t o_branch(input logic we);
    outs_t o = '0;
    o.alu_src_a = 1'b1; o.alu_op = 4'd1; o.pc_src = 2'b01; o.pc_we = we;
    return o;
  endfunction
  function automatic outs_t o_jump(input logic [1:0] src, input logic link);
    outs_t o = '0;
    o.pc_we = 1'b1; o.pc_src = src;
    if (link) begin o.reg_we = 1'b1; o.reg_dst = 2'b10; o.mem_to_reg = 2'b10; end
    return o;
  endfunction
  function automatic outs_t o_halt();
    outs_t o = '0;
    o.illegal = 1'b1;
    return o;
  endfunction

  function automatic vec_t v(input logic [8*12-1:0] name, input logic rn,
                             input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input logic rdy, input outs_t exp);
    vec_t r;
    r.name = name; r.rn = rn; r.op = op; r.fn = fn; r.z = z; r.rdy = rdy; r.exp = exp;
    return r;
  endfunction

  // One cycle: drive on the falling edge, compare 1 ns later, before the next rise.
  task automatic apply(input vec_t t);
    outs_t got;
    @(negedge clk);
    reset_n = t.rn; opcode = t.op; funct = t.fn; zero = t.z; mem_ready = t.rdy;
    #1;
    got = '{pc_we, pc_src, ir_we, iord, mem_re, mem_we, reg_we, reg_dst,
            mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal};
    checks++;
    if (got !== t.exp) begin
      errors++;
      $display("FAIL %0s: got %h expected %h", t.name, got, t.exp);
    end
  endtask

  initial begin
    // Reset, then ADD with zero wait states: FETCH DECODE EXEC_R WB_ALU.
    vec_q.push_back(v("rst0",     0, 6'h00, 6'h20, 0, 1, o_zero()));
    vec_q.push_back(v("rst1",     0, 6'h00, 6'h20, 0, 1, o_zero()));
    vec_q.push_back(v("add_f",    1, 6'h00, 6'h20, 0, 1, o_fetch(1)));
    vec_q.push_back(v("add_d",    1, 6'h00, 6'h20, 0, 1, o_decode()));
    vec_q.push_back(v("add_x",    1, 6'h00, 6'h20, 0, 1, o_exec_r(4'd0)));
    vec_q.push_back(v("add_wb",   1, 6'h00, 6'h20, 0, 1, o_wb_alu(2'b01)));
    // SUB with one fetch wait cycle.
    vec_q.push_back(v("sub_fw",   1, 6'h00, 6'h22, 0, 0, o_fetch(0)));
    vec_q.push_back(v("sub_f",    1, 6'h00, 6'h22, 0, 1, o_fetch(1)));
    vec_q.push_back(v("sub_d",    1, 6'h00, 6'h22, 0, 1, o_decode()));
    vec_q.push_back(v("sub_x",    1, 6'h00, 6'h22, 0, 1, o_exec_r(4'd1)));
    vec_q.push_back(v("sub_wb",   1, 6'h00, 6'h22, 0, 1, o_wb_alu(2'b01)));
    // SLT
    vec_q.push_back(v("slt_f",    1, 6'h00, 6'h2A, 0, 1, o_fetch(1)));
    vec_q.push_back(v("slt_d",    1, 6'h00, 6'h2A, 0, 1, o_decode()));
    vec_q.push_back(v("slt_x",    1, 6'h00, 6'h2A, 0, 1, o_exec_r(4'd3)));
    vec_q.push_back(v("slt_wb",   1, 6'h00, 6'h2A, 0, 1, o_wb_alu(2'b01)));
    // ADDI / XORI write rt
    vec_q.push_back(v("addi_f",   1, 6'h08, 6'h3F, 0, 1, o_fetch(1)));
    vec_q.push_back(v("addi_d",   1, 6'h08, 6'h3F, 0, 1, o_decode()));
    vec_q.push_back(v("addi_x",   1, 6'h08, 6'h3F, 0, 1, o_exec_i(4'd0)));
    vec_q.push_back(v("addi_wb",  1, 6'h08, 6'h3F, 0, 1, o_wb_alu(2'b00)));
    vec_q.push_back(v("xori_f",   1, 6'h0E, 6'h00, 0, 1, o_fetch(1)));
    vec_q.push_back(v("xori_d",   1, 6'h0E, 6'h00, 0, 1, o_decode()));
    vec_q.push_back(v("xori_x",   1, 6'h0E, 6'h00, 0, 1, o_exec_i(4'd2)));
    vec_q.push_back(v("xori_wb",  1, 6'h0E, 6'h00, 0, 1, o_wb_alu(2'b00)));
    // LW with two MEM_READ wait cycles: 7 cycles total.
    vec_q.push_back(v("lw_f",     1, 6'h23, 6'h00, 0, 1, o_fetch(1)));
    vec_q.push_back(v("lw_d",     1, 6'h23, 6'h00, 0, 1, o_decode()));
    vec_q.push_back(v("lw_a",     1, 6'h23, 6'h00, 0, 0, o_mem_addr()));
    vec_q.push_back(v("lw_rw0",   1, 6'h23, 6'h00, 0, 0, o_mem_read()));
    vec_q.push_back(v("lw_rw1",   1, 6'h23, 6'h00, 0, 0, o_mem_read()));
    vec_q.push_back(v("lw_r",     1, 6'h23, 6'h00, 0, 1, o_mem_read()));
    vec_q.push_back(v("lw_wb",    1, 6'h23, 6'h00, 0, 1, o_wb_mem()));
    // SW, zero waits
    vec_q.push_back(v("sw_f",     1, 6'h2B, 6'h00, 0, 1, o_fetch(1)));
    vec_q.push_back(v("sw_d",     1, 6'h2B, 6'h00, 0, 1, o_decode()));
    vec_q.push_back(v("sw_a",     1, 6'h2B, 6'h00, 0, 1, o_mem_addr()));
    vec_q.push_back(v("sw_w",     1, 6'h2B, 6'h00, 0, 1, o_mem_write()));
    // BNE not taken (zero=1), then taken (zero=0)
    vec_q.push_back(v("bne1_f",   1, 6'h05, 6'h00, 1, 1, o_fetch(1)));
    vec_q.push_back(v("bne1_d",   1, 6'h05, 6'h00, 1, 1, o_decode()));
    vec_q.push_back(v("bne1_b",   1, 6'h05, 6'h00, 1, 1, o_branch(0)));
    vec_q.push_back(v("bne0_f",   1, 6'h05, 6'h00, 0, 1, o_fetch(1)));
    vec_q.push_back(v("bne0_d",   1, 6'h05, 6'h00, 0, 1, o_decode()));
    vec_q.push_back(v("bne0_b",   1, 6'h05, 6'h00, 0, 1, o_branch(1)));
    // J, JAL, JR
    vec_q.push_back(v("j_f",      1, 6'h02, 6'h00, 0, 1, o_fetch(1)));
    vec_q.push_back(v("j_d",      1, 6'h02, 6'h00, 0, 1, o_decode()));
    vec_q.push_back(v("j_j",      1, 6'h02, 6'h00, 0, 1, o_jump(2'b10, 0)));
    vec_q.push_back(v("jal_f",    1, 6'h03, 6'h00, 0, 1, o_fetch(1)));
    vec_q.push_back(v("jal_d",    1, 6'h03, 6'h00, 0, 1, o_decode()));
    vec_q.push_back(v("jal_j",    1, 6'h03, 6'h00, 0, 1, o_jump(2'b10, 1)));
    vec_q.push_back(v("jr_f",     1, 6'h00, 6'h08, 0, 1, o_fetch(1)));
    vec_q.push_back(v("jr_d",     1, 6'h00, 6'h08, 0, 1, o_decode()));
    vec_q.push_back(v("jr_j",     1, 6'h00, 6'h08, 0, 1, o_jump(2'b11, 0)));
    vec_q.push_back(v("post_jr",  1, 6'h00, 6'h00, 0, 0, o_fetch(0)));

    foreach (vec_q[i]) apply(vec_q[i]);

    // Illegal opcode 0x3F: HALT is sticky, mem_ready toggling enables nothing.
    apply(v("ill_f",    1, 6'h3F, 6'h00, 0, 1, o_fetch(1)));
    apply(v("ill_d",    1, 6'h3F, 6'h00, 0, 1, o_decode()));
    for (int i = 0; i < 4; i++)
      apply(v("ill_halt", 1, 6'h3F, 6'h00, i[0], i[0], o_halt()));
    apply(v("ill_rst",  0, 6'h3F, 6'h00, 0, 1, o_zero()));
    apply(v("ill_post", 1, 6'h3F, 6'h00, 0, 0, o_fetch(0)));

    // Unsupported R-type funct also halts.
    apply(v("fn_f",     1, 6'h00, 6'h21, 0, 1, o_fetch(1)));
    apply(v("fn_d",     1, 6'h00, 6'h21, 0, 1, o_decode()));
    apply(v("fn_halt",  1, 6'h00, 6'h21, 0, 1, o_halt()));
    apply(v("fn_rst",   0, 6'h00, 6'h21, 0, 1, o_zero()));

    // Reset in the middle of a MEM_WRITE wait abandons the store.
    apply(v("rw_f",     1, 6'h2B, 6'h00, 0, 1, o_fetch(1)));
    apply(v("rw_d",     1, 6'h2B, 6'h00, 0, 1, o_decode()));
    apply(v("rw_a",     1, 6'h2B, 6'h00, 0, 0, o_mem_addr()));
    apply(v("rw_wait",  1, 6'h2B, 6'h00, 0, 0, o_mem_write()));
    apply(v("rw_rst",   0, 6'h2B, 6'h00, 0, 0, o_zero()));
    for (int i = 0; i < 3; i++)
      apply(v("rw_post",  1, 6'h2B, 6'h00, 0, 0, o_fetch(0)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
